// File: rtl/fft_frame_feeder.sv
// rtl/fft_frame_feeder.sv - decimating ping-pong frame buffer feeding the FFT sink stream
// Optional DC remover on kept samples when DC_BLOCK_EN is defined.
module fft_frame_feeder #(
    parameter int FRAME_LEN = 1024,
    parameter int LOG2_LEN  = 10,
    parameter int OUT_W     = 16,
    parameter int DECIM     = 4
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [31:0]         sample_data,
    output logic                sink_valid,
    input  logic                sink_ready,
    output logic                sink_sop,
    output logic                sink_eop,
    output logic [OUT_W-1:0]    sink_real,
    output logic [OUT_W-1:0]    sink_imag,
    output logic [1:0]          sink_error,
    output logic [LOG2_LEN:0]   fftpts_in,
    output logic                overrun,
    output logic [15:0]         frames_out
);
    localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int PW  = LOG2_LEN + 1;
    localparam logic [LOG2_LEN-1:0] LAST_IDX = LOG2_LEN'(FRAME_LEN - 1);
    localparam logic [DCW-1:0]      DEC_LAST = DCW'(DECIM - 1);

    typedef enum logic [1:0] {IDLE, PREFETCH, STREAM} rd_state_t;

    rd_state_t           state, state_nxt;
    logic [DCW-1:0]      dec_cnt;
    logic [LOG2_LEN-1:0] wr_idx, rd_idx, rd_idx_nxt;
    logic                wr_bank, rd_bank;
    logic [1:0]          full;
    logic                keep, wr_en, fill_evt, free_evt, xfer;
    logic [LOG2_LEN:0]   rd_addr;
    logic [OUT_W-1:0]    x, y, rd_q;
    logic [OUT_W-1:0]    mem [2*FRAME_LEN];
    logic                sample_unused;

    assign x             = sample_data[31 -: OUT_W];
    assign sample_unused = ^sample_data[31-OUT_W:0];
    assign keep          = sample_valid && (dec_cnt == '0);
    assign wr_en         = keep && !full[wr_bank];
    assign fill_evt      = wr_en && (wr_idx == LAST_IDX);

`ifdef DC_BLOCK_EN
    logic [OUT_W+7:0] acc;
    logic [OUT_W-1:0] mean;
    logic [OUT_W:0]   diff;

    assign mean = acc[OUT_W+7:8];
    assign diff = {x[OUT_W-1], x} - {mean[OUT_W-1], mean};

    always_comb begin
        y = diff[OUT_W-1:0];
        if (diff[OUT_W] != diff[OUT_W-1])
            y = diff[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end

    // The mean tracks every kept sample, even one dropped on overrun.
    always_ff @(posedge CLOCK_50) begin
        if (reset)
            acc <= '0;
        else if (keep)
            acc <= acc + {{7{diff[OUT_W]}}, diff};
    end
`else
    assign y = x;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            dec_cnt <= '0;
            wr_idx  <= '0;
            wr_bank <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (sample_valid)
                dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + 1'b1;
            if (keep) begin
                if (full[wr_bank]) begin
                    overrun <= 1'b1;
                    wr_idx  <= '0;
                end else if (wr_idx == LAST_IDX) begin
                    wr_idx  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (wr_en)
            mem[{wr_bank, wr_idx}] <= y;
    end

    // The read register is also the output register: re-reading the same
    // address while stalled keeps sink_real stable.
    always_ff @(posedge CLOCK_50) begin
        if (reset)
            rd_q <= '0;
        else
            rd_q <= mem[rd_addr];
    end

    // Fill and free never target the same bank in one cycle.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            full <= '0;
        end else begin
            if (fill_evt)
                full[wr_bank] <= 1'b1;
            if (free_evt)
                full[rd_bank] <= 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= IDLE;
            rd_idx     <= '0;
            rd_bank    <= 1'b0;
            frames_out <= '0;
        end else begin
            state  <= state_nxt;
            rd_idx <= rd_idx_nxt;
            if (free_evt) begin
                rd_bank    <= ~rd_bank;
                frames_out <= frames_out + 16'd1;
            end
        end
    end

    assign sink_valid = (state == STREAM);
    assign xfer       = sink_valid && sink_ready;

    always_comb begin
        state_nxt  = state;
        rd_idx_nxt = rd_idx;
        free_evt   = 1'b0;
        case (state)
            IDLE: begin
                rd_idx_nxt = '0;
                if (full[rd_bank])
                    state_nxt = PREFETCH;
            end
            PREFETCH: state_nxt = STREAM;
            STREAM: begin
                if (xfer) begin
                    rd_idx_nxt = rd_idx + 1'b1;
                    if (rd_idx == LAST_IDX) begin
                        free_evt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        rd_addr = {rd_bank, rd_idx_nxt};
    end

    assign sink_sop   = sink_valid && (rd_idx == '0);
    assign sink_eop   = sink_valid && (rd_idx == LAST_IDX);
    assign sink_real  = rd_q;
    assign sink_imag  = '0;
    assign sink_error = 2'b00;
    assign fftpts_in  = PW'(FRAME_LEN);
endmodule

// File: tb/tb_fft_frame_feeder.sv
// tb/tb_fft_frame_feeder.sv - self-checking bench: two feeders (DECIM 1 and 4) against a stream-level model
module tb_fft_frame_feeder;
    localparam int FL = 8;
    localparam int LG = 3;
    localparam int W  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          sv1, sv4, rdy1, rdy4;
    logic [31:0]   sd1, sd4;
    logic          v1, sop1, eop1, ov1, v4, sop4, eop4, ov4;
    logic [W-1:0]  re1, im1, re4, im4;
    logic [1:0]    err1, err4;
    logic [LG:0]   pts1, pts4;
    logic [15:0]   fr1, fr4;

    fft_frame_feeder #(.FRAME_LEN(FL), .LOG2_LEN(LG), .OUT_W(W), .DECIM(1)) u_d1 (
        .CLOCK_50(clk), .reset(reset), .sample_valid(sv1), .sample_data(sd1),
        .sink_valid(v1), .sink_ready(rdy1), .sink_sop(sop1), .sink_eop(eop1),
        .sink_real(re1), .sink_imag(im1), .sink_error(err1), .fftpts_in(pts1),
        .overrun(ov1), .frames_out(fr1));

    fft_frame_feeder #(.FRAME_LEN(FL), .LOG2_LEN(LG), .OUT_W(W), .DECIM(4)) u_d4 (
        .CLOCK_50(clk), .reset(reset), .sample_valid(sv4), .sample_data(sd4),
        .sink_valid(v4), .sink_ready(rdy4), .sink_sop(sop4), .sink_eop(eop4),
        .sink_real(re4), .sink_imag(im4), .sink_error(err4), .fftpts_in(pts4),
        .overrun(ov4), .frames_out(fr4));

    int compared = 0;
    int mismatched = 0;

    // Model: expected word streams, position within frame, completed frames.
    logic [15:0] q1[$], q4[$];
    int pos1 = 0, pos4 = 0, frames1 = 0, frames4 = 0, n4 = 0;
    int mode1 = 1, mode4 = 1;
    logic stall1 = 1'b0, stall4 = 1'b0;
    logic [15:0] re1_d = '0, re4_d = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic next_ready(input int m, input logic cur);
        case (m)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return ~cur;
            default: return ($urandom_range(3) != 0);
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        rdy1 = next_ready(mode1, rdy1);
        rdy4 = next_ready(mode4, rdy4);
    end

    always @(negedge clk) begin
        if (reset) begin
            stall1 = 1'b0;
            stall4 = 1'b0;
        end else begin
            if (pos1 != 0 || stall1) check("d1_valid_in_frame", 32'(v1), 1);
            if (stall1) check("d1_stall_stable", 32'(re1), 32'(re1_d));
            if (v1 && rdy1) begin
                check("d1_word_expected", 32'(q1.size() != 0), 1);
                if (q1.size() != 0) check("d1_real", 32'(re1), 32'(q1.pop_front()));
                check("d1_sop", 32'(sop1), 32'(pos1 == 0));
                check("d1_eop", 32'(eop1), 32'(pos1 == FL - 1));
                if (pos1 == FL - 1) frames1++;
                pos1 = (pos1 + 1) % FL;
            end
            stall1 = v1 && !rdy1;
            re1_d  = re1;

            if (pos4 != 0 || stall4) check("d4_valid_in_frame", 32'(v4), 1);
            if (stall4) check("d4_stall_stable", 32'(re4), 32'(re4_d));
            if (v4 && rdy4) begin
                check("d4_word_expected", 32'(q4.size() != 0), 1);
                if (q4.size() != 0) check("d4_real", 32'(re4), 32'(q4.pop_front()));
                check("d4_sop", 32'(sop4), 32'(pos4 == 0));
                check("d4_eop", 32'(eop4), 32'(pos4 == FL - 1));
                if (pos4 == FL - 1) frames4++;
                pos4 = (pos4 + 1) % FL;
            end
            stall4 = v4 && !rdy4;
            re4_d  = re4;
        end
    end

    task automatic strobe1(input logic [15:0] v, input bit expect_keep);
        @(posedge clk); #1;
        sv1 = 1'b1;
        sd1 = {v, 16'($urandom)};
        if (expect_keep) q1.push_back(v);
        @(posedge clk); #1;
        sv1 = 1'b0;
    endtask

    task automatic strobe4(input logic [15:0] v);
        @(posedge clk); #1;
        sv4 = 1'b1;
        sd4 = {v, 16'($urandom)};
        if (n4 % 4 == 0) q4.push_back(v);
        n4++;
        @(posedge clk); #1;
        sv4 = 1'b0;
    endtask

    task automatic drain(input int which, input int budget);
        int c = 0;
        while (((which == 1) ? (q1.size() != 0 || pos1 != 0) : (q4.size() != 0 || pos4 != 0))
               && c < budget) begin
            @(posedge clk);
            c++;
        end
        check("drain_in_budget", 32'(c < budget), 1);
        repeat (2) @(posedge clk);
        #1;
        if (which == 1) check("d1_frames_out", 32'(fr1), 32'(frames1 & 16'hffff));
        else            check("d4_frames_out", 32'(fr4), 32'(frames4 & 16'hffff));
    endtask

    task automatic check_consts;
        check("d1_imag", 32'(im1), 0);
        check("d1_error", 32'(err1), 0);
        check("d1_fftpts", 32'(pts1), FL);
        check("d4_imag", 32'(im4), 0);
        check("d4_fftpts", 32'(pts4), FL);
    endtask

    initial begin
        int c;
        reset = 1'b1; sv1 = 1'b0; sv4 = 1'b0; sd1 = '0; sd4 = '0; rdy1 = 1'b1; rdy4 = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state.
        check("rst_d1_valid", 32'(v1), 0);
        check("rst_d1_sop", 32'(sop1), 0);
        check("rst_d1_eop", 32'(eop1), 0);
        check("rst_d1_real", 32'(re1), 0);
        check("rst_d1_overrun", 32'(ov1), 0);
        check("rst_d1_frames", 32'(fr1), 0);
        check("rst_d4_valid", 32'(v4), 0);
        check_consts();

        // One frame, ready held high; valid within 3 cycles of the filling write.
        mode1 = 1;
        for (int k = 0; k < FL; k++) strobe1(16'(k), 1'b1);
        c = 0;
        while (!v1 && c < 10) begin @(posedge clk); #1; c++; end
        check("d1_fill_latency", 32'(c <= 3), 1);
        drain(1, 100);
        check("d1_no_overrun", 32'(ov1), 0);

        // Same values, ready toggling.
        mode1 = 2;
        for (int k = 0; k < FL; k++) strobe1(16'(k), 1'b1);
        drain(1, 100);

        // Both banks full under backpressure: 17..24 dropped.
        mode1 = 0;
        for (int k = 1; k <= 3 * FL; k++) strobe1(16'(k), k <= 2 * FL);
        repeat (4) @(posedge clk);
        #1;
        check("d1_overrun_set", 32'(ov1), 1);
        check("d1_stalled_valid", 32'(v1), 1);
        check("d1_stalled_sop", 32'(sop1), 1);
        check("d1_stalled_real", 32'(re1), 1);
        mode1 = 1;
        drain(1, 200);
        for (int k = 3 * FL + 1; k <= 4 * FL; k++) strobe1(16'(k), 1'b1);
        drain(1, 100);
        check("d1_overrun_sticky", 32'(ov1), 1);
        check_consts();

        // Decimation by 4.
        mode4 = 1;
        for (int k = 0; k < 4 * FL; k++) strobe4(16'(k));
        drain(4, 100);
        check("d4_no_overrun", 32'(ov4), 0);

        // Randomized streams with random backpressure, paced to avoid overrun.
        mode1 = 3;
        for (int i = 0; i < 5 * FL; i++) begin
            strobe1(16'($urandom), 1'b1);
            repeat ($urandom_range(1, 4)) @(posedge clk);
        end
        drain(1, 400);
        mode4 = 3;
        for (int i = 0; i < 12 * FL; i++) begin
            strobe4(16'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain(4, 400);
        check("d1_overrun_still", 32'(ov1), 1);

        // Reset mid-frame.
        mode1 = 2;
        for (int k = 0; k < FL; k++) strobe1(16'(16'h100 + k), 1'b1);
        c = 0;
        while (pos1 < 3 && c < 200) begin @(posedge clk); c++; end
        check("d1_midframe_reached", 32'(c < 200), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        q1.delete(); q4.delete();
        pos1 = 0; pos4 = 0; frames1 = 0; frames4 = 0; n4 = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("mid_rst_valid", 32'(v1), 0);
        check("mid_rst_overrun", 32'(ov1), 0);
        check("mid_rst_frames", 32'(fr1), 0);
        check_consts();

        // Clean frame after the aborted one.
        mode1 = 1;
        for (int k = 0; k < FL; k++) strobe1(16'($urandom), 1'b1);
        drain(1, 100);
        check_consts();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
